// File: rtl/stream_packet_arbiter.sv
// Packet-granular round-robin arbiter feeding one registered byte-count stream sink.
// A port that wins arbitration keeps the sink until its last beat is accepted.
module stream_packet_arbiter #(
    parameter int unsigned DATA_BYTES = 8,
    parameter int unsigned NUM_PORTS  = 4,
    localparam int unsigned DATA_BITS = DATA_BYTES * 8,
    localparam int unsigned CNT_BITS  = $clog2(DATA_BYTES),
    localparam int unsigned ID_BITS   = $clog2(NUM_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS*DATA_BITS-1:0] in_data,
    input  logic [NUM_PORTS*CNT_BITS-1:0]  in_cnt,
    input  logic [NUM_PORTS-1:0]           in_last,
    input  logic [NUM_PORTS-1:0]           in_valid,
    output logic [NUM_PORTS-1:0]           in_ready,
    output logic [DATA_BITS-1:0]           out_data,
    output logic [CNT_BITS-1:0]            out_cnt,
    output logic                           out_last,
    output logic [ID_BITS-1:0]             out_id,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam logic ST_ARB = 1'b0;
    localparam logic ST_PKT = 1'b1;

    logic                 state_q, state_d;
    logic [ID_BITS-1:0]   rr_q, rr_d;
    logic [ID_BITS-1:0]   grant_q, grant_d;

    logic [ID_BITS-1:0]   winner;
    logic                 found;
    logic [ID_BITS-1:0]   sel;
    logic [ID_BITS-1:0]   sel_next;
    logic                 sel_valid;
    logic                 stage_free;
    logic                 xfer;
    logic [DATA_BITS-1:0] sel_data;
    logic [CNT_BITS-1:0]  sel_cnt;
    logic                 sel_last;

    // Round-robin search for the first valid port starting at rr_q
    always_comb begin
        int unsigned idx;
        logic [ID_BITS-1:0] idx_id;
        found  = 1'b0;
        winner = rr_q;
        idx    = 0;
        idx_id = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            idx_id = ID_BITS'(idx);
            if (!found && in_valid[idx_id]) begin
                found  = 1'b1;
                winner = idx_id;
            end
        end
    end

    // Select the serving port and derive handshakes; in_ready is held low during reset
    always_comb begin
        stage_free = !out_valid | out_ready;
        sel        = (state_q == ST_PKT) ? grant_q : winner;
        sel_valid  = (state_q == ST_PKT) ? in_valid[grant_q] : found;
        sel_next   = (sel == ID_BITS'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
        in_ready   = '0;
        if (rst_n && ((state_q == ST_PKT) || found)) begin
            in_ready[sel] = stage_free;
        end
        xfer = rst_n & sel_valid & stage_free;
    end

    // Mux the selected port's beat fields
    always_comb begin
        sel_data = '0;
        sel_cnt  = '0;
        sel_last = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (ID_BITS'(p) == sel) begin
                sel_data = in_data[p*DATA_BITS +: DATA_BITS];
                sel_cnt  = in_cnt[p*CNT_BITS +: CNT_BITS];
                sel_last = in_last[p];
            end
        end
    end

    // Ownership and round-robin pointer updates, driven by accepted beats only
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        if (xfer) begin
            if (sel_last) begin
                state_d = ST_ARB;
                rr_d    = sel_next;
            end else begin
                state_d = ST_PKT;
                grant_d = sel;
            end
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARB;
            rr_q    <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
        end
    end

    // Output stage: load on transfer, drain when the sink takes the beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
            out_last  <= 1'b0;
            out_id    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_cnt   <= sel_cnt;
            out_last  <= sel_last;
            out_id    <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Directed bench for stream_packet_arbiter with per-port source queues and an output scoreboard.
module tb_stream_packet_arbiter;

    localparam int DB = 8;
    localparam int NP = 4;
    localparam int DW = DB * 8;
    localparam int CW = 3;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP*DW-1:0]  in_data;
    logic [NP*CW-1:0]  in_cnt;
    logic [NP-1:0]     in_last;
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     in_ready;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_cnt;
    logic              out_last;
    logic [IW-1:0]     out_id;
    logic              out_valid;
    logic              out_ready;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] cnt;
        logic          last;
        logic [IW-1:0] id;
    } beat_t;

    beat_t       srcq[NP][$];
    beat_t       expq[$];
    logic [NP-1:0] en;
    logic [NP-1:0] acc;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    stream_packet_arbiter #(
        .DATA_BYTES (DB),
        .NUM_PORTS  (NP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_last  (out_last),
        .out_id    (out_id),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic logic [DW-1:0] mk(int p, int n);
        return 64'hB0DE_0000_0000_0000 | (64'(p) << 16) | 64'(n);
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Queue a beat at its source and, in predicted output order, on the scoreboard
    task automatic beat(int p, int n, logic [CW-1:0] c, logic l);
        beat_t b;
        b.data = mk(p, n);
        b.cnt  = c;
        b.last = l;
        b.id   = IW'(p);
        srcq[p].push_back(b);
        expq.push_back(b);
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (en[p] && srcq[p].size() != 0) begin
                in_valid[p]          = 1'b1;
                in_data[p*DW +: DW]  = srcq[p][0].data;
                in_cnt[p*CW +: CW]   = srcq[p][0].cnt;
                in_last[p]           = srcq[p][0].last;
            end else begin
                in_valid[p]          = 1'b0;
                in_data[p*DW +: DW]  = '0;
                in_cnt[p*CW +: CW]   = '0;
                in_last[p]           = 1'b0;
            end
        end
    endtask

    // Called at a falling edge: apply inputs, then sample handshakes and score the output
    task automatic tick_pre();
        beat_t got;
        drive();
        #1;
        acc = in_valid & in_ready;
        if (out_valid && out_ready) begin
            n_vec++;
            assert (expq.size() != 0) else begin
                n_err++;
                $error("FAIL spurious_beat: observed id %0d data %0h expected no beat",
                       out_id, out_data);
            end
            if (expq.size() != 0) begin
                got = {out_data, out_cnt, out_last, out_id};
                chk("out_beat", 128'(got), 128'(expq.pop_front()));
            end
        end
    endtask

    task automatic tick_post();
        beat_t d;
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            if (acc[p]) begin
                d = srcq[p].pop_front();
            end
        end
        @(negedge clk);
    endtask

    task automatic tick();
        tick_pre();
        tick_post();
    endtask

    task automatic drain(string tag);
        for (int i = 0; i < 40; i++) begin
            if (expq.size() == 0) break;
            tick();
        end
        chk(tag, 128'(expq.size()), 128'(0));
    endtask

    task automatic clear_queues();
        expq.delete();
        for (int p = 0; p < NP; p++) srcq[p].delete();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        clear_queues();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        en        = '1;
        out_ready = 1'b1;
        in_data   = '0;
        in_cnt    = '0;
        in_last   = '0;
        in_valid  = '1;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #1;
        // Reset values, with every port requesting
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data",  128'(out_data),  128'(0));
        chk("rst_out_cnt",   128'(out_cnt),   128'(0));
        chk("rst_out_last",  128'(out_last),  128'(0));
        chk("rst_out_id",    128'(out_id),    128'(0));
        chk("rst_in_ready",  128'(in_ready),  128'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: three-beat packet from port 0, cnt 0,0,5
        beat(0, 0, 3'd0, 1'b0);
        beat(0, 1, 3'd0, 1'b0);
        beat(0, 2, 3'd5, 1'b1);
        tick_pre();
        chk("t1_ready", 128'(in_ready), 128'(4'b0001));
        chk("t1_no_out_yet", 128'(out_valid), 128'(0));
        tick_post();
        tick_pre();
        chk("t1_latency", 128'(out_valid), 128'(1));
        tick_post();
        drain("t1_drain");

        // 2: ports 0 and 2 after reset, packets do not interleave
        reset_dut();
        beat(0, 0, 3'd1, 1'b0);
        beat(0, 1, 3'd2, 1'b1);
        beat(2, 0, 3'd3, 1'b0);
        beat(2, 1, 3'd4, 1'b1);
        tick_pre();
        chk("t2_ready", 128'(in_ready), 128'(4'b0001));
        tick_post();
        drain("t2_drain");
        // Pointer now at 3: port 3 beats port 0
        beat(3, 5, 3'd0, 1'b1);
        beat(0, 5, 3'd0, 1'b1);
        drain("t2_rr3_drain");

        // 3: port 1 stalls mid-packet while port 3 waits
        beat(1, 0, 3'd1, 1'b0);
        beat(1, 1, 3'd2, 1'b0);
        beat(1, 2, 3'd3, 1'b0);
        beat(1, 3, 3'd4, 1'b1);
        beat(3, 0, 3'd1, 1'b0);
        beat(3, 1, 3'd2, 1'b1);
        tick_pre();
        chk("t3_arb_ready", 128'(in_ready), 128'(4'b0010));
        tick_post();
        en[1] = 1'b0;
        tick_pre();
        chk("t3_hold_ready_a", 128'(in_ready), 128'(4'b0010));
        tick_post();
        tick_pre();
        chk("t3_hold_ready_b", 128'(in_ready), 128'(4'b0010));
        chk("t3_bubble", 128'(out_valid), 128'(0));
        tick_post();
        en[1] = 1'b1;
        drain("t3_drain");

        // 4: output backpressure holds the stage and blocks inputs
        beat(0, 0, 3'd6, 1'b0);
        beat(0, 1, 3'd7, 1'b0);
        beat(0, 2, 3'd1, 1'b1);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_pre();
            chk("t4_in_ready", 128'(in_ready),  128'(0));
            chk("t4_valid",    128'(out_valid), 128'(1));
            chk("t4_data",     128'(out_data),  128'(mk(0, 0)));
            chk("t4_cnt",      128'(out_cnt),   128'(6));
            chk("t4_id",       128'(out_id),    128'(0));
            tick_post();
        end
        out_ready = 1'b1;
        drain("t4_drain");
        for (int i = 0; i < 3; i++) tick();

        // 5: all ports, single-beat packets, one beat per cycle
        reset_dut();
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < NP; p++) beat(p, r, 3'(p), 1'b1);
        end
        for (int i = 0; i < 9; i++) tick();
        chk("t5_throughput", 128'(expq.size()), 128'(0));

        // 6: asynchronous reset mid-packet on port 2
        beat(2, 0, 3'd0, 1'b0);
        beat(2, 1, 3'd0, 1'b0);
        beat(2, 2, 3'd0, 1'b1);
        tick();
        tick();
        chk("t6_pre_valid", 128'(out_valid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 128'(out_valid), 128'(0));
        chk("t6_async_data",  128'(out_data),  128'(0));
        chk("t6_async_ready", 128'(in_ready),  128'(0));
        clear_queues();
        @(negedge clk);
        rst_n = 1'b1;
        beat(1, 0, 3'd2, 1'b0);
        beat(1, 1, 3'd3, 1'b1);
        beat(2, 7, 3'd4, 1'b1);
        tick_pre();
        chk("t6_ready", 128'(in_ready), 128'(4'b0010));
        tick_post();
        drain("t6_drain");
        for (int i = 0; i < 2; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
